stream_demux: RTL
=================

STREAM_DEMUX -- requirements
Module: stream_demux

Interface
REQ-001 Parameter DATA_W, 8, payload width in bits (>=1).
REQ-002 Parameter NUM_CH, 4, number of output channels (2..16, need not be a power of two).
REQ-003 Parameter CNT_W, 16, width of each per-channel transfer counter (used only with DEMUX_CNT_EN).
REQ-004 Derived constant SEL_W = clog2(NUM_CH), minimum 1.
REQ-005 clk  in  1  single clock, all state on rising edge.
REQ-006 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-007 in_valid  in  1  upstream word present.
REQ-008 in_ready  out  1  block accepts the word this cycle.
REQ-009 in_data  in  DATA_W  upstream payload.
REQ-010 in_sel  in  SEL_W  destination channel index.
REQ-011 out_valid  out  NUM_CH  per-channel word present.
REQ-012 out_ready  in  NUM_CH  per-channel downstream accept.
REQ-013 out_data  out  NUM_CH*DATA_W  channel k at bits [k*DATA_W +: DATA_W].
REQ-014 err_sel  out  1  sticky flag: an out-of-range in_sel was accepted.
REQ-015 cnt  out  NUM_CH*CNT_W  per-channel transfer counts, present only with DEMUX_CNT_EN.

Function
REQ-016 Each channel SHALL own a one-entry holding register (valid bit + DATA_W data).
REQ-017 in_ready SHALL be combinational: 1 if in_sel >= NUM_CH, else (~out_valid[in_sel] | out_ready[in_sel]).
REQ-018 Input handshake = in_valid & in_ready; output handshake k = out_valid[k] & out_ready[k].
REQ-019 On input handshake with in_sel = k < NUM_CH, channel k register SHALL load in_data and set out_valid[k] next cycle (latency 1).
REQ-020 Simultaneous output handshake and refill on the same channel SHALL keep out_valid[k]=1 with new data (one word per cycle per channel sustained).
REQ-021 Output handshake without refill SHALL clear out_valid[k] next cycle.
REQ-022 out_data slice k SHALL read all-zero whenever out_valid[k]=0; non-selected channels never change.
REQ-023 out_valid[k]=1 with out_ready[k]=0 SHALL hold data stable; in_ready for sel=k is then 0, other channels unaffected (no head-of-line blocking beyond the selected channel).
REQ-024 On input handshake with in_sel >= NUM_CH the word SHALL be discarded and err_sel set next cycle; err_sel clears only on reset.
REQ-025 in_valid=0 SHALL never alter any channel state; in_sel/in_data are don't-care then.

Reset
REQ-026 rst_n low SHALL asynchronously force out_valid=0, out_data=0, err_sel=0, cnt=0.
REQ-027 Reset mid-transfer SHALL discard all held words; first accept after release is normal.
REQ-028 in_ready after reset SHALL be 1 for any in_sel (all channels empty).

Configuration
REQ-029 Macro STREAM_DEMUX_CNT_EN defined: cnt port and per-channel counters exist; counter k increments by 1 on each output handshake k, saturates at all-ones.
REQ-030 Macro undefined: no cnt port, no counter logic; all other behaviour identical.

Structure
REQ-031 Package stream_demux_pkg SHALL hold default DATA_W/NUM_CH/CNT_W constants and the SEL_W width function.
REQ-032 Sub-module demux_chan_reg (one-entry register: load, drain, valid, zero-masked data, optional counter) SHALL be instantiated NUM_CH times via generate.

Verification
REQ-033 Reset, in_sel=2, in_data=8'hA5, in_valid 1 cycle, all out_ready=0 -> next cycle out_valid=4'b0100, slice 2=8'hA5, others 8'h00.
REQ-034 Channel 1 full, out_ready[1]=0, send sel=1 -> in_ready=0; send sel=3 same cycle -> in_ready=1, out_valid[3] next cycle.
REQ-035 out_ready=4'hF, stream sel=0 data 1..8 back-to-back -> in_ready held 1, channel 0 emits 1..8 one per cycle, cnt[0]=8 (CNT_EN).
REQ-036 NUM_CH=3, in_sel=3, in_valid=1 -> in_ready=1, no out_valid change, err_sel=1 next cycle and stays 1.
REQ-037 Channels 0 and 2 full, rst_n pulsed low mid-cycle -> out_valid=0, out_data=0, err_sel=0 immediately, before next clk edge.
REQ-038 CNT_W=2, 5 transfers on channel 1 -> cnt[1] saturates at 3.

Source files
------------

// File: rtl/stream_demux_pkg.sv
// ----------------------------------------------------------------------------
// stream_demux_pkg
//
// Shared definitions for the stream demultiplexer slice:
//   - default payload width, channel count and transfer-counter width
//   - sel_width(): width of the channel-select field for a given channel count
//
// Optional feature macro used by the files that import this package:
//   STREAM_DEMUX_CNT_EN  adds per-channel saturating transfer counters and the
//                        cnt output port.
// ----------------------------------------------------------------------------
package stream_demux_pkg;

    // Default build: 4 channels of 8-bit payload, 16-bit transfer counters.
    localparam int DEFAULT_DATA_W = 8;
    localparam int DEFAULT_NUM_CH = 4;
    localparam int DEFAULT_CNT_W  = 16;

    // Legal channel-count range of the demux.
    localparam int MIN_NUM_CH = 2;
    localparam int MAX_NUM_CH = 16;

    // Width of the channel-select field. A single channel would need zero
    // select bits, so the width is clamped to at least one bit to keep the
    // port well-formed.
    function automatic int sel_width(input int num_ch);
        return (num_ch > 1) ? $clog2(num_ch) : 1;
    endfunction

endpackage : stream_demux_pkg

// File: rtl/stream_demux_chan.sv
// ----------------------------------------------------------------------------
// demux_chan_reg
//
// One output channel of the stream demultiplexer: a one-entry holding
// register (valid bit + payload) with a valid/ready drain side.
//
// Behaviour:
//   - load  : capture load_data and present it next cycle. The parent only
//             asserts load when the slot is empty or is being drained in the
//             same cycle, so a load never overwrites an undelivered word.
//   - drain : valid & ready; without a simultaneous load the slot empties.
//   - data  : reads all-zero while the slot is empty.
//
// Optional feature (macro STREAM_DEMUX_CNT_EN):
//   cnt counts drain handshakes on this channel and saturates at all-ones.
//
// Ports:
//   clk        in   clock, all state on the rising edge
//   rst_n      in   asynchronous active-low reset
//   load       in   accepted upstream word is destined for this channel
//   load_data  in   payload to capture on load
//   ready      in   downstream accept for this channel
//   valid      out  slot holds a word
//   data       out  held payload, zero while empty
//   cnt        out  drain handshake count (STREAM_DEMUX_CNT_EN only)
// ----------------------------------------------------------------------------
module demux_chan_reg
    import stream_demux_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W
`ifdef STREAM_DEMUX_CNT_EN
   ,parameter int CNT_W  = DEFAULT_CNT_W
`endif
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [DATA_W-1:0] load_data,
    input  logic              ready,
    output logic              valid,
    output logic [DATA_W-1:0] data
`ifdef STREAM_DEMUX_CNT_EN
   ,output logic [CNT_W-1:0]  cnt
`endif
);

    logic              valid_q;
    logic [DATA_W-1:0] data_q;
    logic              drain;

    assign drain = valid_q & ready;

    // A load wins over a drain: when both happen in one cycle the old word
    // leaves downstream and the new one takes its place, which keeps a
    // channel streaming at one word per cycle.
    // NOTE: state registers use non-blocking assignments so every flop in the
    // design samples the pre-edge values regardless of block evaluation order.
    // NOTE: the payload register is reset alongside the valid bit. The output
    // is zero-masked anyway, but a reset payload keeps the slot free of stale
    // words from before a reset and costs nothing for a single entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            if (load) begin
                valid_q <= 1'b1;
                data_q  <= load_data;
            end else if (drain) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign valid = valid_q;
    assign data  = valid_q ? data_q : '0;

`ifdef STREAM_DEMUX_CNT_EN
    logic [CNT_W-1:0] cnt_q;

    // Saturating count of delivered words; sticks at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (drain && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign cnt = cnt_q;
`endif

endmodule : demux_chan_reg

// File: rtl/stream_demux.sv
// ----------------------------------------------------------------------------
// stream_demux
//
// Routes a single valid/ready input stream to one of NUM_CH output streams
// selected per word by in_sel. Each channel buffers one word, so a stalled
// channel only blocks words addressed to itself; words for other channels
// keep flowing. A word accepted with an out-of-range in_sel (possible when
// NUM_CH is not a power of two) is dropped and raises the sticky err_sel
// flag, which clears only on reset.
//
// Optional feature (macro STREAM_DEMUX_CNT_EN):
//   adds the cnt port with one saturating CNT_W-bit transfer counter per
//   channel, counting output handshakes.
//
// Parameters:
//   DATA_W  payload width (>= 1)
//   NUM_CH  number of output channels (2..16)
//   CNT_W   per-channel counter width (used with STREAM_DEMUX_CNT_EN)
//   SEL_W   derived select width, clog2(NUM_CH) with a minimum of 1
//
// Ports:
//   clk        in   clock, all state on the rising edge
//   rst_n      in   asynchronous active-low reset
//   in_valid   in   upstream word present
//   in_ready   out  word accepted this cycle (combinational)
//   in_data    in   upstream payload
//   in_sel     in   destination channel index
//   out_valid  out  per-channel word present
//   out_ready  in   per-channel downstream accept
//   out_data   out  channel k payload at [k*DATA_W +: DATA_W], zero when empty
//   err_sel    out  sticky: an out-of-range in_sel was accepted
//   cnt        out  channel k count at [k*CNT_W +: CNT_W] (STREAM_DEMUX_CNT_EN)
// ----------------------------------------------------------------------------
module stream_demux
    import stream_demux_pkg::*;
#(
    parameter  int DATA_W = DEFAULT_DATA_W,
    parameter  int NUM_CH = DEFAULT_NUM_CH,
    parameter  int CNT_W  = DEFAULT_CNT_W,
    localparam int SEL_W  = sel_width(NUM_CH)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [DATA_W-1:0]        in_data,
    input  logic [SEL_W-1:0]         in_sel,
    output logic [NUM_CH-1:0]        out_valid,
    input  logic [NUM_CH-1:0]        out_ready,
    output logic [NUM_CH*DATA_W-1:0] out_data,
    output logic                     err_sel
`ifdef STREAM_DEMUX_CNT_EN
   ,output logic [NUM_CH*CNT_W-1:0]  cnt
`endif
);

    localparam int SEL_SPACE = 2 ** SEL_W;

    // ------------------------------------------------------------------------
    // Elaboration-time parameter legality
    // ------------------------------------------------------------------------
    if (DATA_W < 1 || CNT_W < 1 || NUM_CH < MIN_NUM_CH || NUM_CH > MAX_NUM_CH)
    begin : g_bad_params
        $error("stream_demux: DATA_W/CNT_W must be >= 1 and NUM_CH in 2..16");
    end

    // ------------------------------------------------------------------------
    // Select decode
    //
    // Both tables span the full select space so they can be indexed directly
    // by in_sel. Codes at or above NUM_CH always accept (the word is dropped)
    // and are marked out-of-range; in-range codes accept when that channel's
    // slot is empty or is being drained this cycle.
    // ------------------------------------------------------------------------
    logic [SEL_SPACE-1:0] ready_by_sel;
    logic [SEL_SPACE-1:0] oob_by_sel;

    for (genvar s = 0; s < SEL_SPACE; s++) begin : g_sel
        if (s < NUM_CH) begin : g_in_range
            assign ready_by_sel[s] = ~out_valid[s] | out_ready[s];
            assign oob_by_sel[s]   = 1'b0;
        end else begin : g_out_of_range
            assign ready_by_sel[s] = 1'b1;
            assign oob_by_sel[s]   = 1'b1;
        end
    end

    logic accept;

    assign in_ready = ready_by_sel[in_sel];
    assign accept   = in_valid & in_ready;

    // ------------------------------------------------------------------------
    // Sticky out-of-range select flag
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_sel <= 1'b0;
        end else if (accept && oob_by_sel[in_sel]) begin
            err_sel <= 1'b1;
        end
    end

    // ------------------------------------------------------------------------
    // Channel holding registers
    // ------------------------------------------------------------------------
    for (genvar k = 0; k < NUM_CH; k++) begin : g_chan
        logic load;

        // Only the addressed channel sees the accepted word.
        assign load = accept & (in_sel == SEL_W'(k));

        demux_chan_reg #(
            .DATA_W    (DATA_W)
`ifdef STREAM_DEMUX_CNT_EN
           ,.CNT_W     (CNT_W)
`endif
        ) u_chan (
            .clk       (clk),
            .rst_n     (rst_n),
            .load      (load),
            .load_data (in_data),
            .ready     (out_ready[k]),
            .valid     (out_valid[k]),
            .data      (out_data[k*DATA_W +: DATA_W])
`ifdef STREAM_DEMUX_CNT_EN
           ,.cnt       (cnt[k*CNT_W +: CNT_W])
`endif
        );
    end

endmodule : stream_demux
